// File: rtl/pio_wifi_status_in.sv
// Avalon-MM input PIO for the WiFi module's status lines. Each bit is synchronised,
// debounced and edge-detected into a sticky W1C capture register that drives a maskable irq.
module pio_wifi_status_in #(
    parameter int unsigned DATA_WIDTH      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [1:0]  EDGE_RESET      = 2'b00
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        EM_RISE = 2'b00,
        EM_FALL = 2'b01,
        EM_ANY  = 2'b10,
        EM_OFF  = 2'b11
    } edge_mode_e;

    logic [DATA_WIDTH-1:0] s1_q, s2_q;
    logic [DATA_WIDTH-1:0] ds_q, ds_d;
    logic [DATA_WIDTH-1:0] ds_dly_q;
    logic [CW-1:0]         cnt_q [DATA_WIDTH];
    logic [CW-1:0]         cnt_d [DATA_WIDTH];
    edge_mode_e            edge_mode_q, edge_mode_d;
    logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [31:0]           readdata_q, readdata_d;

    logic                  rd_en, wr_en;
    logic [DATA_WIDTH-1:0] rise, fall, event_bits, clr_bits;
    logic                  unused_wdata;

    assign rd_en        = chipselect && write_n;
    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        ds_d = ds_q;
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (s2_q[i] == ds_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                ds_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Edges are taken from the registered debounced value, so capture lags ds by one cycle.
    always_comb begin
        rise = ds_q & ~ds_dly_q;
        fall = ~ds_q & ds_dly_q;
        unique case (edge_mode_q)
            EM_RISE: event_bits = rise;
            EM_FALL: event_bits = fall;
            EM_ANY:  event_bits = rise | fall;
            EM_OFF:  event_bits = '0;
            default: event_bits = '0;
        endcase
    end

    always_comb begin
        edge_mode_d = edge_mode_q;
        irq_mask_d  = irq_mask_q;
        clr_bits    = '0;
        if (wr_en) begin
            unique case (address)
                2'd1:    edge_mode_d = edge_mode_e'(writedata[1:0]);
                2'd2:    irq_mask_d  = writedata[DATA_WIDTH-1:0];
                2'd3:    clr_bits    = writedata[DATA_WIDTH-1:0];
                default: ;
            endcase
        end
        // A new event in the same cycle as its W1C clear must not be lost.
        edge_cap_d = (edge_cap_q & ~clr_bits) | event_bits;
    end

    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            unique case (address)
                2'd0:    readdata_d = 32'(ds_q);
                2'd1:    readdata_d = {30'd0, edge_mode_q};
                2'd2:    readdata_d = 32'(irq_mask_q);
                2'd3:    readdata_d = 32'(edge_cap_q);
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            ds_q        <= '0;
            ds_dly_q    <= '0;
            cnt_q       <= '{default: '0};
            edge_mode_q <= edge_mode_e'(EDGE_RESET);
            irq_mask_q  <= '0;
            edge_cap_q  <= '0;
            readdata_q  <= '0;
        end else begin
            s1_q        <= in_port;
            s2_q        <= s1_q;
            ds_q        <= ds_d;
            ds_dly_q    <= ds_q;
            cnt_q       <= cnt_d;
            edge_mode_q <= edge_mode_d;
            irq_mask_q  <= irq_mask_d;
            edge_cap_q  <= edge_cap_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_wifi_status_in.sv
// Directed bench for pio_wifi_status_in: expectations queued when stimulus is applied,
// popped and asserted against readdata/irq when the DUT produces them.
module tb_pio_wifi_status_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    pio_wifi_status_in #(
        .DATA_WIDTH     (4),
        .DEBOUNCE_CYCLES(16),
        .EDGE_RESET     (2'b00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic compare_obs(input logic [31:0] obs);
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %h expected <queued value>", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic check_irq(input string tag, input logic e);
        expect_val(tag, {31'd0, e});
        compare_obs({31'd0, irq});
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string tag);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        expect_val(tag, e);
        @(posedge clk);
        #1;
        compare_obs(readdata);
        chipselect = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // Reset with all inputs high.
        wait_cycles(3);
        expect_val("reset_readdata", 32'h0);
        compare_obs(readdata);
        check_irq("reset_irq", 1'b0);

        @(negedge clk);
        reset_n = 1'b1;
        repeat (17) @(posedge clk);
        bus_read(2'd0, 32'h0, "data_edge18_old");
        bus_read(2'd0, 32'hF, "data_edge19_new");
        bus_read(2'd3, 32'hF, "cap_rise_all");
        check_irq("irq_mask_zero", 1'b0);
        bus_write(2'd3, 32'hF);
        bus_read(2'd3, 32'h0, "cap_w1c_all");

        // Falls are ignored in rising mode; then a short glitch on bit 0.
        @(negedge clk);
        in_port = 4'h0;
        wait_cycles(25);
        bus_read(2'd3, 32'h0, "no_cap_on_fall");
        @(negedge clk);
        in_port[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        in_port[0] = 1'b0;
        wait_cycles(30);
        bus_read(2'd0, 32'h0, "glitch_data");
        bus_read(2'd3, 32'h0, "glitch_cap");
        check_irq("glitch_irq", 1'b0);

        // Falling mode with bit 1 unmasked.
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'h2);
        @(negedge clk);
        in_port[1] = 1'b1;
        wait_cycles(25);
        bus_read(2'd3, 32'h0, "fall_mode_ignores_rise");
        @(negedge clk);
        in_port[1] = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check_irq("irq_before_cap", 1'b0);
        @(posedge clk);
        #1;
        check_irq("irq_with_cap", 1'b1);
        bus_read(2'd3, 32'h2, "cap_fall");
        bus_read(2'd3, 32'h2, "cap_read_no_clear");
        bus_read(2'd0, 32'h0, "data_after_fall");

        // W1C clear colliding with a new capture on the same bit.
        bus_write(2'd1, 32'h2);
        @(negedge clk);
        in_port[1] = 1'b1;
        repeat (18) @(posedge clk);
        bus_write(2'd3, 32'h2);
        check_irq("w1c_collision_irq", 1'b1);
        bus_read(2'd3, 32'h2, "w1c_collision_cap");
        bus_write(2'd3, 32'h2);
        check_irq("w1c_clear_irq", 1'b0);
        bus_read(2'd3, 32'h0, "w1c_clear_cap");

        // Masking and capture-disabled mode.
        bus_write(2'd2, 32'h0);
        bus_write(2'd1, 32'h0);
        @(negedge clk);
        in_port[0] = 1'b1;
        wait_cycles(25);
        bus_read(2'd3, 32'h1, "cap_bit0_masked");
        check_irq("irq_masked", 1'b0);
        bus_write(2'd2, 32'h1);
        check_irq("irq_unmask", 1'b1);
        bus_write(2'd1, 32'h3);
        @(negedge clk);
        in_port[2] = 1'b1;
        wait_cycles(25);
        bus_read(2'd3, 32'h1, "mode_off_no_set");
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, 32'h0, "mode_off_clear");
        check_irq("mode_off_irq", 1'b0);

        // Back-to-back reads of the whole map, then hold on non-read cycles.
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            case (a)
                0:       expect_val("b2b_data", 32'h7);
                1:       expect_val("b2b_mode", 32'h3);
                2:       expect_val("b2b_mask", 32'h1);
                default: expect_val("b2b_cap", 32'h0);
            endcase
            @(posedge clk);
            #1;
            compare_obs(readdata);
            @(negedge clk);
        end
        chipselect = 1'b0;
        bus_read(2'd2, 32'h1, "read_mask");
        bus_write(2'd2, 32'h1);
        wait_cycles(3);
        expect_val("hold_nonread", 32'h1);
        compare_obs(readdata);

        // Asynchronous reset while irq is high.
        bus_write(2'd1, 32'h0);
        @(negedge clk);
        in_port[3] = 1'b1;
        wait_cycles(25);
        bus_write(2'd2, 32'h8);
        check_irq("irq_bit3", 1'b1);
        bus_read(2'd3, 32'h8, "cap_bit3");
        #2;
        reset_n = 1'b0;
        #1;
        check_irq("async_reset_irq", 1'b0);
        expect_val("async_reset_readdata", 32'h0);
        compare_obs(readdata);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (17) @(posedge clk);
        bus_read(2'd0, 32'h0, "reacquire_edge18_old");
        bus_read(2'd0, 32'hF, "reacquire_edge19_new");
        bus_read(2'd1, 32'h0, "mode_after_reset");
        bus_read(2'd2, 32'h0, "mask_after_reset");
        bus_read(2'd3, 32'hF, "cap_after_reset");
        check_irq("irq_after_reset", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_wifi_status_in.md
Name: pio_wifi_status_in

Overview:
- Avalon-MM slave input PIO that samples the WiFi module's status/ready lines (`in_port`) for the Nios/HPS software. It is the read-side counterpart of the WiFi reset output PIO.
- Synchronises and debounces each input bit, latches edges into a sticky capture register, and raises a maskable level interrupt.
- Sits on the same lightweight Avalon bus as the other WiFi PIOs.

Parameters:
- DATA_WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed before a bit's debounced value changes (1..65535).
- EDGE_RESET, 0, reset value of the 2-bit edge-mode register.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset; asynchronous, active-low; clock is clk.
- address  input  2  word address of the register.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a read is chipselect && write_n.
- writedata  input  32  write data.
- in_port  input  DATA_WIDTH  asynchronous external status lines.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt, active-high.

Behaviour:
- Register map:
  - 0 DATA (RO): debounced value ds[DATA_WIDTH-1:0]; writes ignored.
  - 1 EDGEMODE (RW, bits[1:0]): 00 rising, 01 falling, 10 any, 11 capture disabled.
  - 2 IRQMASK (RW, DATA_WIDTH bits).
  - 3 EDGECAP (R, W1C, DATA_WIDTH bits).
- Unused readdata bits always read 0.
- Reset (async, reset_n=0):
  - sync stages, ds, ds_d, counters, IRQMASK, EDGECAP all 0.
  - EDGEMODE = EDGE_RESET; readdata = 0; irq = 0.
- Synchroniser: two flops per bit, s1 <= in_port, s2 <= s1. No combinational path from in_port to any register other than s1.
- Debounce, per bit i, with a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits:
  - If s2[i]==ds[i]: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: ds[i] <= s2[i] and counter <= 0.
  - Else: counter <= counter+1.
- Debounce latency and filtering:
  - An in_port step held stable reaches ds exactly 2+DEBOUNCE_CYCLES clock edges after the first sampling edge.
  - Glitches shorter than DEBOUNCE_CYCLES cycles at s2 never reach ds.
- Edge detect: ds_d <= ds. A rise is ds & ~ds_d; a fall is ~ds & ds_d. The event is qualified by EDGEMODE.
- EDGECAP update, per bit, evaluated each cycle:
  - Bit is set by a qualified event.
  - Bit is cleared by a write to address 3 with writedata[i]=1.
  - Set wins if both occur in the same cycle.
  - Otherwise the bit holds.
  - Capture therefore appears 1 cycle after ds changes.
- irq = |(EDGECAP & IRQMASK), driven combinationally from registers. It therefore follows an EDGECAP or IRQMASK change with no extra cycle.
- Writes to addresses 1 and 2 take effect on the write edge. A write to IRQMASK that unmasks an already-set EDGECAP bit raises irq the same cycle the new mask is registered.
- Reads: on a read cycle, readdata <= the selected register (read latency 1). On non-read cycles readdata holds its last value.
- A read of EDGECAP does not clear it.
- EDGEMODE change: takes effect for events from the next cycle. Already-captured bits are unaffected. Mode 11 blocks new sets but still allows clears.
- Reset asserted mid-debounce or with irq high: all state returns to reset values immediately, irq drops asynchronously. After release, ds re-acquires inputs through the full sync+debounce path.

Test Plan:
- Reset with in_port=4'hF, DEBOUNCE_CYCLES=16 -> readdata=0 and irq=0 during reset. After release, DATA reads 0xF only from clock edge 18 on (2 sync + 16 debounce). EDGECAP[3:0]=0xF under rising mode.
- Glitch: hold in_port[0]=1 for 10 cycles, then 0 -> DATA[0] stays 0, EDGECAP stays 0, irq stays 0.
- Falling mode (EDGEMODE=01), IRQMASK=0x2, in_port[1] 1->0 held 20 cycles -> EDGECAP=0x2 exactly 1 cycle after DATA[1] falls; irq=1 in the same cycle as EDGECAP.
- W1C collision: write EDGECAP=0x2 on the same cycle a new in_port[1] edge is captured -> EDGECAP[1] stays 1 and irq stays 1. A later write of 0x2 with no event -> EDGECAP=0, irq=0.
- Mask/mode: EDGECAP=0x1 with IRQMASK=0 -> irq=0. Write IRQMASK=0x1 -> irq=1 next cycle. EDGEMODE=11 with a rising edge on bit 2 -> EDGECAP[2] stays 0.
- Reads: read addresses 0..3 back-to-back -> each readdata is valid 1 cycle after its read cycle. Bits [31:DATA_WIDTH] = 0, and EDGEMODE reads 0x0000000X with X in 0..3.
